// File: rtl/hwpe_ctrl_mult_sched.sv
// Sum-of-products scheduler: takes a batch of up to NB_TERMS operand pairs, issues them one at a
// time to a sequential multiplier and accumulates the signed products into one result.
module hwpe_ctrl_mult_sched #(
    parameter int AW       = 8,
    parameter int BW       = 8,
    parameter int NB_TERMS = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    clear_i,
    input  logic                                    req_valid_i,
    output logic                                    req_ready_o,
    input  logic [NB_TERMS*AW-1:0]                  req_a_i,
    input  logic [NB_TERMS*BW-1:0]                  req_b_i,
    input  logic [NB_TERMS-1:0]                     req_invert_i,
    input  logic [$clog2(NB_TERMS+1)-1:0]           req_nterms_i,
    output logic                                    res_valid_o,
    input  logic                                    res_ready_i,
    output logic [AW+BW+$clog2(NB_TERMS)-1:0]       res_sum_o,
    output logic                                    mult_clear_o,
    output logic                                    mult_start_o,
    output logic [AW-1:0]                           mult_a_o,
    output logic [BW-1:0]                           mult_b_o,
    output logic                                    mult_invert_o,
    input  logic                                    mult_ready_i,
    input  logic                                    mult_valid_i,
    input  logic [AW+BW-1:0]                        mult_prod_i,
    output logic [1:0]                              dbg_state_o
);

    localparam int OW  = AW + BW + $clog2(NB_TERMS);
    localparam int NTW = $clog2(NB_TERMS + 1);
    localparam int IW  = (NB_TERMS > 1) ? $clog2(NB_TERMS) : 1;
    localparam int CW  = NTW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high.
    // The sender holds valid and payload stable until that edge; ready never depends on valid.

    logic [1:0]             state;
    logic [NB_TERMS*AW-1:0] a_q;
    logic [NB_TERMS*BW-1:0] b_q;
    logic [NB_TERMS-1:0]    inv_q;
    logic [NTW-1:0]         nterms_q;
    logic [IW-1:0]          idx;
    logic [OW-1:0]          acc;
    logic [AW-1:0]          op_a;
    logic [BW-1:0]          op_b;
    logic                   op_inv;
    logic                   wait_first;

    logic [NTW-1:0]         nterms_clamped;
    logic [IW-1:0]          idx_next;
    logic                   last_term;
    logic [OW-1:0]          prod_ext;

    assign nterms_clamped = (req_nterms_i > NTW'(NB_TERMS)) ? NTW'(NB_TERMS) : req_nterms_i;
    assign idx_next       = idx + IW'(1);
    assign last_term      = ((CW'(idx) + CW'(1)) == CW'(nterms_q));
    // The product is signed with negation already applied; widen by sign extension.
    assign prod_ext       = OW'($signed(mult_prod_i));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            inv_q      <= '0;
            nterms_q   <= '0;
            idx        <= '0;
            acc        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_inv     <= 1'b0;
            wait_first <= 1'b0;
        end else if (clear_i) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            inv_q      <= '0;
            nterms_q   <= '0;
            idx        <= '0;
            acc        <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_inv     <= 1'b0;
            wait_first <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        a_q      <= req_a_i;
                        b_q      <= req_b_i;
                        inv_q    <= req_invert_i;
                        nterms_q <= nterms_clamped;
                        idx      <= '0;
                        acc      <= '0;
                        // Term 0 operands come straight from the request so they are ready in ISSUE.
                        op_a     <= req_a_i[AW-1:0];
                        op_b     <= req_b_i[BW-1:0];
                        op_inv   <= req_invert_i[0];
                        state    <= (nterms_clamped == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (mult_ready_i) begin
                        wait_first <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // The first WAIT cycle may still show the previous operation's valid.
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (mult_valid_i) begin
                        acc <= acc + prod_ext;
                        if (last_term) begin
                            state <= DONE;
                        end else begin
                            idx    <= idx_next;
                            op_a   <= a_q[idx_next*AW +: AW];
                            op_b   <= b_q[idx_next*BW +: BW];
                            op_inv <= inv_q[idx_next];
                            state  <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    if (res_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = (state == IDLE);
    assign res_valid_o   = (state == DONE);
    assign res_sum_o     = acc;
    assign mult_clear_o  = clear_i;
    assign mult_start_o  = (state == ISSUE) && mult_ready_i && !clear_i;
    assign mult_a_o      = op_a;
    assign mult_b_o      = op_b;
    assign mult_invert_o = op_inv;
    assign dbg_state_o   = state;

endmodule

// File: tb/tb_hwpe_ctrl_mult_sched.sv
// Bench for hwpe_ctrl_mult_sched: a latency-configurable multiplier model feeds the DUT and an
// arithmetic sum-of-products reference supplies expected results, latencies and operand order.
module tb_hwpe_ctrl_mult_sched;

    localparam int AW  = 8;
    localparam int BW  = 8;
    localparam int NB  = 4;
    localparam int OW  = 18;
    localparam int NTW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [NB*AW-1:0]  req_a = '0;
    logic [NB*BW-1:0]  req_b = '0;
    logic [NB-1:0]     req_inv = '0;
    logic [NTW-1:0]    req_n = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [OW-1:0]     res_sum;
    logic              mult_clear;
    logic              mult_start;
    logic [AW-1:0]     mult_a;
    logic [BW-1:0]     mult_b;
    logic              mult_inv;
    logic              mult_ready;
    logic              mult_valid;
    logic [AW+BW-1:0]  mult_prod;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;

    hwpe_ctrl_mult_sched #(.AW(AW), .BW(BW), .NB_TERMS(NB)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_a_i(req_a), .req_b_i(req_b), .req_invert_i(req_inv), .req_nterms_i(req_n),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_sum_o(res_sum),
        .mult_clear_o(mult_clear), .mult_start_o(mult_start),
        .mult_a_o(mult_a), .mult_b_o(mult_b), .mult_invert_o(mult_inv),
        .mult_ready_i(mult_ready), .mult_valid_i(mult_valid), .mult_prod_i(mult_prod),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- multiplier model ----------------
    // valid rises L cycles after the start cycle and stays up (stale) until after the next start.
    int            lat = 2;
    logic          ready_en = 1'b1;
    int            mcnt = 0;
    logic          mvalid = 1'b0;
    logic [15:0]   mprod = '0;
    logic [AW-1:0] cap_a = '0;
    logic [BW-1:0] cap_b = '0;
    logic          op_active = 1'b0;
    int            start_total = 0;
    int            bad_start = 0;
    int            hold_err = 0;
    logic [16:0]   obs_q[$];
    logic [16:0]   exp_q[$];

    assign mult_ready = ready_en && (mcnt == 0);
    assign mult_valid = mvalid;
    assign mult_prod  = mprod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcnt <= 0; mvalid <= 1'b0; mprod <= '0; op_active <= 1'b0;
        end else if (mult_clear) begin
            mcnt <= 0; mvalid <= 1'b0; op_active <= 1'b0;
        end else if (mult_start) begin
            if (!mult_ready) bad_start <= bad_start + 1;
            mcnt      <= lat - 1;
            cap_a     <= mult_a;
            cap_b     <= mult_b;
            op_active <= 1'b1;
            mprod     <= mult_inv ? 16'(-(int'(mult_a) * int'(mult_b))) : 16'(int'(mult_a) * int'(mult_b));
            start_total <= start_total + 1;
            obs_q.push_back({mult_inv, mult_a, mult_b});
        end else if (mcnt > 0) begin
            mcnt   <= mcnt - 1;
            mvalid <= (mcnt == 1);
        end else if (mvalid && op_active) begin
            op_active <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (op_active && (mult_a !== cap_a || mult_b !== cap_b)) hold_err++;
    end

    // ---------------- reference model ----------------
    function automatic int clamp_n(input int n);
        return (n > NB) ? NB : n;
    endfunction

    function automatic logic [OW-1:0] ref_sum(input int n, input logic [NB*AW-1:0] a,
                                              input logic [NB*BW-1:0] b, input logic [NB-1:0] inv);
        int s = 0;
        for (int k = 0; k < clamp_n(n); k++) begin
            int p = int'(a[k*AW +: AW]) * int'(b[k*BW +: BW]);
            s += inv[k] ? -p : p;
        end
        return OW'(s);
    endfunction

    function automatic logic [NB*AW-1:0] rand_ops();
        logic [NB*AW-1:0] v;
        for (int k = 0; k < NB; k++) v[k*AW +: AW] = 8'($urandom_range(0, 127));
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    int acc_cyc = 0;
    int base_starts = 0;

    task automatic send_req(input int n, input logic [NB*AW-1:0] a, input logic [NB*BW-1:0] b,
                            input logic [NB-1:0] inv);
        int got = 0;
        exp_q.delete();
        obs_q.delete();
        for (int k = 0; k < clamp_n(n); k++) exp_q.push_back({inv[k], a[k*AW +: AW], b[k*BW +: BW]});
        base_starts = start_total;
        req_a = a; req_b = b; req_inv = inv; req_n = NTW'(n); req_valid = 1'b1;
        for (int t = 0; t < 100 && got == 0; t++) begin
            if (req_ready) got = 1;
            else @(negedge clk);
        end
        checks++;
        if (got == 0) begin
            errors++;
            $display("FAIL req_accept: req_ready got %0b required 1 within 100 cycles", req_ready);
        end
        acc_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_a = rand_ops(); req_b = rand_ops(); req_inv = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_result(input logic [OW-1:0] exp_sum, input int exp_lat, input int exp_starts,
                               input string name);
        int got = 0;
        int bad = 0;
        for (int t = 0; t < 500 && got == 0; t++) begin
            if (res_valid) got = 1;
            else @(negedge clk);
        end
        checks++;
        if (got == 0) begin
            errors++;
            $display("FAIL %s_timeout: res_valid got 0 required 1 within 500 cycles", name);
            return;
        end
        checks++;
        if (cyc - acc_cyc !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", name, cyc - acc_cyc, exp_lat);
        end
        checks++;
        if (res_sum !== exp_sum) begin
            errors++;
            $display("FAIL %s_sum: got %h required %h", name, res_sum, exp_sum);
        end
        checks++;
        if (start_total - base_starts !== exp_starts) begin
            errors++;
            $display("FAIL %s_starts: got %0d required %0d", name, start_total - base_starts, exp_starts);
        end
        if (obs_q.size() != exp_q.size()) bad = 1;
        else for (int i = 0; i < exp_q.size(); i++) if (obs_q[i] !== exp_q[i]) bad = 1;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_operands: got %0d ops required %0d ops in order", name, obs_q.size(), exp_q.size());
        end
        checks++;
        if (hold_err !== 0 || bad_start !== 0) begin
            errors++;
            $display("FAIL %s_protocol: hold_err %0d bad_start %0d required 0 0", name, hold_err, bad_start);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: res_valid %0b req_ready %0b required 0 1", name, res_valid, req_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || mult_start !== 1'b0 || res_sum !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: ready %0b valid %0b start %0b sum %h required 1 0 0 0",
                     req_ready, res_valid, mult_start, res_sum);
        end
        checks++;
        if (mult_a !== '0 || mult_b !== '0 || mult_inv !== 1'b0) begin
            errors++;
            $display("FAIL reset_ops: a %h b %h inv %0b required 0 0 0", mult_a, mult_b, mult_inv);
        end
    endtask

    task automatic test_basic();
        lat = 2;
        send_req(2, 32'h0000_0503, 32'h0000_0604, 4'b0000);
        wait_result(18'd42, 7, 2, "t1");
        send_req(2, 32'h0000_0503, 32'h0000_0604, 4'b0010);
        wait_result(18'h3FFEE, 7, 2, "t2");
        send_req(0, 32'h0000_0503, 32'h0000_0604, 4'b0000);
        wait_result(18'd0, 1, 0, "t3");
        send_req(7, 32'h0201_0503, 32'h0807_0604, 4'b0100);
        wait_result(18'd42 - 18'd7 + 18'd16, 13, 4, "clamp");
    endtask

    task automatic test_done_hold();
        int got = 0;
        lat = 2;
        send_req(1, 32'h0000_0007, 32'h0000_0009, 4'b0000);
        for (int t = 0; t < 50 && got == 0; t++) begin
            if (res_valid) got = 1;
            else @(negedge clk);
        end
        checks++;
        if (got == 0 || cyc - acc_cyc !== 4) begin
            errors++;
            $display("FAIL t4_latency: got %0d required 4", cyc - acc_cyc);
        end
        req_valid = 1'b1; req_n = 3'd2; req_a = 32'h0000_0101; req_b = 32'h0000_0101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_sum !== 18'd63 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL t4_hold: valid %0b sum %0d ready %0b required 1 63 0", res_valid, res_sum, req_ready);
            end
        end
        res_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (start_total - base_starts !== 1 || req_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL t4_no_accept: starts %0d ready %0b valid %0b required 1 1 0",
                     start_total - base_starts, req_ready, res_valid);
        end
    endtask

    task automatic test_stall();
        lat = 2;
        ready_en = 1'b0;
        send_req(1, 32'h0000_000B, 32'h0000_000D, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (mult_start !== 1'b0) begin
                errors++;
                $display("FAIL t5_stall: mult_start got %0b required 0", mult_start);
            end
        end
        @(posedge clk);
        #1 ready_en = 1'b1;
        @(negedge clk);
        checks++;
        if (mult_start !== 1'b1 || mult_a !== 8'd11 || mult_b !== 8'd13) begin
            errors++;
            $display("FAIL t5_start: start %0b a %0d b %0d required 1 11 13", mult_start, mult_a, mult_b);
        end
        wait_result(18'd143, 7, 1, "t5");
    endtask

    task automatic test_abort(input bit use_rst);
        int got = 0;
        int seen = 0;
        lat = 2;
        send_req(2, 32'h0000_0503, 32'h0000_0604, 4'b0000);
        for (int t = 0; t < 50 && got == 0; t++) begin
            @(negedge clk);
            if (mult_start && (start_total - base_starts) == 1) got = 1;
        end
        checks++;
        if (got == 0) begin
            errors++;
            $display("FAIL t6_second_start: got 0 required 1");
        end
        @(negedge clk);
        if (use_rst) begin
            #1 rst_n = 1'b0;
            #1;
        end else begin
            clear = 1'b1;
            checks++;
            if (mult_clear !== 1'b1) begin
                errors++;
                $display("FAIL t6_mult_clear: got %0b required 1", mult_clear);
            end
            @(negedge clk);
            clear = 1'b0;
        end
        checks++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_sum !== '0 || mult_a !== '0 || mult_b !== '0) begin
            errors++;
            $display("FAIL t6_idle: ready %0b valid %0b sum %h a %h b %h required 1 0 0 0 0",
                     req_ready, res_valid, res_sum, mult_a, mult_b);
        end
        if (use_rst) begin
            @(negedge clk);
            rst_n = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        checks++;
        if (seen !== 0 || mult_clear !== 1'b0) begin
            errors++;
            $display("FAIL t6_no_result: res_valid cycles %0d mult_clear %0b required 0 0", seen, mult_clear);
        end
        send_req(2, 32'h0000_0503, 32'h0000_0604, 4'b0000);
        wait_result(18'd42, 7, 2, use_rst ? "t6_rst" : "t6_clr");
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 12; it++) begin
            int n = $urandom_range(0, 7);
            logic [NB*AW-1:0] a = rand_ops();
            logic [NB*BW-1:0] b = rand_ops();
            logic [NB-1:0] inv = 4'($urandom_range(0, 15));
            lat = $urandom_range(2, 4);
            send_req(n, a, b, inv);
            wait_result(ref_sum(n, a, b, inv), 1 + clamp_n(n) * (lat + 1), clamp_n(n), "rand");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_done_hold();
        test_stall();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
